// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the pipelined ID stage: opcodes, function codes,
// ALU op/type encodings and the zero/NOP defaults.
package id_stage_pipe_pkg;

  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;

  localparam logic [5:0] EXE_AND = 6'b100100;
  localparam logic [5:0] EXE_OR  = 6'b100101;
  localparam logic [5:0] EXE_XOR = 6'b100110;
  localparam logic [5:0] EXE_NOR = 6'b100111;
  localparam logic [5:0] EXE_SLL = 6'b000000;
  localparam logic [5:0] EXE_SRL = 6'b000010;
  localparam logic [5:0] EXE_SRA = 6'b000011;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  localparam logic [4:0]  NOPRegAddr = 5'b00000;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  function automatic logic is_nop_word(input logic [31:0] word);
    return (word == ZeroWord);
  endfunction

endpackage

// File: rtl/id_stage_pipe_operand_sel.sv
// Per-port operand resolution: immediate / r0 / EX forward / MEM forward / regfile,
// plus the RAW compare that requests a stall.
module id_operand_sel
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              i_read_en,
  input  logic [REG_AW-1:0] i_addr,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_ex_wreg,
  input  logic [REG_AW-1:0] i_ex_wd,
  input  logic [DATA_W-1:0] i_ex_wdata,
  input  logic              i_ex_is_load,
  input  logic              i_mem_wreg,
  input  logic [REG_AW-1:0] i_mem_wd,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_operand,
  output logic              o_stall
);

  localparam logic FWD = (FWD_EN != 0);

  logic w_nonzero;
  logic w_ex_hit;
  logic w_mem_hit;

  assign w_nonzero = i_read_en && (i_addr != {REG_AW{1'b0}});
  assign w_ex_hit  = w_nonzero && i_ex_wreg && (i_ex_wd == i_addr);
  assign w_mem_hit = w_nonzero && i_mem_wreg && (i_mem_wd == i_addr);

  // Without forwarding any in-flight producer blocks; with it only an EX load does.
  assign o_stall = (w_ex_hit && (i_ex_is_load || !FWD)) || (w_mem_hit && !FWD);

  // Priority mux; the youngest producer (EX) wins over MEM.
  always_comb begin
    o_operand = i_reg_data;
    if (!i_read_en) begin
      o_operand = i_imm;
    end else if (i_addr == {REG_AW{1'b0}}) begin
      o_operand = {DATA_W{1'b0}};
    end else if (FWD && w_ex_hit && !i_ex_is_load) begin
      o_operand = i_ex_wdata;
    end else if (FWD && w_mem_hit) begin
      o_operand = i_mem_wdata;
    end else begin
      o_operand = i_reg_data;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: combinational decode, regfile read with forwarding and
// load-use detection, then an ID/EX output register with valid/ready handshake.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int FWD_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   pc_i,
  input  logic [31:0]         inst_i,
  output logic                reg1_read_o,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic                reg2_read_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                flush_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   pc_o,
  output logic                inst_err_o
);

  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic [REG_AW-1:0]   w_rs;
  logic [REG_AW-1:0]   w_rt;
  logic [REG_AW-1:0]   w_rd;
  logic [DATA_W-1:0]   w_zimm;
  logic [DATA_W-1:0]   w_luimm;
  logic [DATA_W-1:0]   w_sa;

  logic                w_re1;
  logic                w_re2;
  logic [REG_AW-1:0]   w_ra1;
  logic [REG_AW-1:0]   w_ra2;
  logic [DATA_W-1:0]   w_imm1;
  logic [DATA_W-1:0]   w_imm2;
  logic [REG_AW-1:0]   w_wd;
  logic                w_wreg;
  logic [ALUOP_W-1:0]  w_aluop;
  logic [ALUSEL_W-1:0] w_alusel;
  logic                w_err;

  logic [DATA_W-1:0]   w_opnd1;
  logic [DATA_W-1:0]   w_opnd2;
  logic                w_stall1;
  logic                w_stall2;
  logic                w_load_en;
  logic                w_fire;

  logic                r_out_valid;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1;
  logic [DATA_W-1:0]   r_reg2;
  logic [REG_AW-1:0]   r_wd;
  logic                r_wreg;
  logic [DATA_W-1:0]   r_pc;
  logic                r_inst_err;

  assign w_op    = inst_i[31:26];
  assign w_funct = inst_i[5:0];
  assign w_rs    = REG_AW'(inst_i[25:21]);
  assign w_rt    = REG_AW'(inst_i[20:16]);
  assign w_rd    = REG_AW'(inst_i[15:11]);
  assign w_zimm  = DATA_W'(inst_i[15:0]);
  assign w_luimm = DATA_W'(inst_i[15:0]) << (DATA_W - 16);
  assign w_sa    = DATA_W'(inst_i[10:6]);

  // Instruction decode; a port with no read carries its immediate instead.
  always_comb begin
    w_re1    = 1'b0;
    w_re2    = 1'b0;
    w_ra1    = REG_AW'(NOPRegAddr);
    w_ra2    = REG_AW'(NOPRegAddr);
    w_imm1   = DATA_W'(ZeroWord);
    w_imm2   = DATA_W'(ZeroWord);
    w_wd     = REG_AW'(NOPRegAddr);
    w_wreg   = 1'b0;
    w_aluop  = ALUOP_W'(EXE_NOP_OP);
    w_alusel = ALUSEL_W'(EXE_RES_NOP);
    w_err    = 1'b0;
    if (is_nop_word(inst_i)) begin
      w_err = 1'b0;
    end else begin
      case (w_op)
        EXE_ORI, EXE_ANDI, EXE_XORI: begin
          w_re1    = 1'b1;
          w_ra1    = w_rs;
          w_imm2   = w_zimm;
          w_wd     = w_rt;
          w_wreg   = 1'b1;
          w_alusel = ALUSEL_W'(EXE_RES_LOGIC);
          case (w_op)
            EXE_ORI:  w_aluop = ALUOP_W'(EXE_OR_OP);
            EXE_ANDI: w_aluop = ALUOP_W'(EXE_AND_OP);
            default:  w_aluop = ALUOP_W'(EXE_XOR_OP);
          endcase
        end
        EXE_LUI: begin
          w_imm1   = w_luimm;
          w_imm2   = w_luimm;
          w_wd     = w_rt;
          w_wreg   = 1'b1;
          w_aluop  = ALUOP_W'(EXE_OR_OP);
          w_alusel = ALUSEL_W'(EXE_RES_LOGIC);
        end
        EXE_SPECIAL: begin
          w_ra2 = w_rt;
          w_wd  = w_rd;
          case (w_funct)
            EXE_OR, EXE_AND, EXE_XOR, EXE_NOR: begin
              w_re1    = 1'b1;
              w_ra1    = w_rs;
              w_re2    = 1'b1;
              w_wreg   = 1'b1;
              w_alusel = ALUSEL_W'(EXE_RES_LOGIC);
              case (w_funct)
                EXE_OR:  w_aluop = ALUOP_W'(EXE_OR_OP);
                EXE_AND: w_aluop = ALUOP_W'(EXE_AND_OP);
                EXE_XOR: w_aluop = ALUOP_W'(EXE_XOR_OP);
                default: w_aluop = ALUOP_W'(EXE_NOR_OP);
              endcase
            end
            EXE_SLL, EXE_SRL, EXE_SRA: begin
              w_imm1   = w_sa;
              w_re2    = 1'b1;
              w_wreg   = 1'b1;
              w_alusel = ALUSEL_W'(EXE_RES_SHIFT);
              case (w_funct)
                EXE_SLL: w_aluop = ALUOP_W'(EXE_SLL_OP);
                EXE_SRL: w_aluop = ALUOP_W'(EXE_SRL_OP);
                default: w_aluop = ALUOP_W'(EXE_SRA_OP);
              endcase
            end
            default: begin
              w_ra2 = REG_AW'(NOPRegAddr);
              w_wd  = REG_AW'(NOPRegAddr);
              w_err = 1'b1;
            end
          endcase
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  assign reg1_read_o = w_re1;
  assign reg1_addr_o = w_ra1;
  assign reg2_read_o = w_re2;
  assign reg2_addr_o = w_ra2;

  id_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_sel1 (
    .i_read_en(w_re1), .i_addr(w_ra1), .i_imm(w_imm1), .i_reg_data(reg1_data_i),
    .i_ex_wreg(ex_wreg_i), .i_ex_wd(ex_wd_i), .i_ex_wdata(ex_wdata_i), .i_ex_is_load(ex_is_load_i),
    .i_mem_wreg(mem_wreg_i), .i_mem_wd(mem_wd_i), .i_mem_wdata(mem_wdata_i),
    .o_operand(w_opnd1), .o_stall(w_stall1)
  );

  id_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_sel2 (
    .i_read_en(w_re2), .i_addr(w_ra2), .i_imm(w_imm2), .i_reg_data(reg2_data_i),
    .i_ex_wreg(ex_wreg_i), .i_ex_wd(ex_wd_i), .i_ex_wdata(ex_wdata_i), .i_ex_is_load(ex_is_load_i),
    .i_mem_wreg(mem_wreg_i), .i_mem_wd(mem_wd_i), .i_mem_wdata(mem_wdata_i),
    .o_operand(w_opnd2), .o_stall(w_stall2)
  );

  assign w_load_en = out_ready || !r_out_valid;
  assign in_ready  = w_load_en && !(w_stall1 || w_stall2) && !flush_i;
  assign w_fire    = in_valid && in_ready;

  // ID/EX register: flush kills, a stalled consumer holds, otherwise capture or bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_aluop     <= ALUOP_W'(EXE_NOP_OP);
      r_alusel    <= ALUSEL_W'(EXE_RES_NOP);
      r_reg1      <= DATA_W'(ZeroWord);
      r_reg2      <= DATA_W'(ZeroWord);
      r_wd        <= REG_AW'(NOPRegAddr);
      r_wreg      <= 1'b0;
      r_pc        <= DATA_W'(ZeroWord);
      r_inst_err  <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_load_en) begin
      r_out_valid <= w_fire;
      if (w_fire) begin
        r_aluop    <= w_aluop;
        r_alusel   <= w_alusel;
        r_reg1     <= w_opnd1;
        r_reg2     <= w_opnd2;
        r_wd       <= w_wd;
        r_wreg     <= w_wreg;
        r_pc       <= pc_i;
        r_inst_err <= w_err;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign aluop_o    = r_aluop;
  assign alusel_o   = r_alusel;
  assign reg1_o     = r_reg1;
  assign reg2_o     = r_reg2;
  assign wd_o       = r_wd;
  assign wreg_o     = r_wreg;
  assign pc_o       = r_pc;
  assign inst_err_o = r_inst_err;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, forwarding, load-use stall,
// backpressure, flush, undecodable words and asynchronous reset.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, out_valid, out_ready;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, inst_err_o;

  logic [31:0] rf [32];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg2_read_o(reg2_read_o),
    .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
    .inst_err_o(inst_err_o)
  );

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] funct);
    return {6'h00, rs, rt, rd, sa, funct};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'h0000_00FF;
    rf[2] = 32'h0000_0022;
    rf[4] = 32'h0000_0F0F;
    rst = 1'b0; in_valid = 1'b0; pc_i = 32'h0; inst_i = 32'h0;
    ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
    flush_i = 1'b0; out_ready = 1'b1;

    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_aluop", {24'd0, aluop_o}, 32'h00);
    chk("rst_alusel", {29'd0, alusel_o}, 32'd0);
    chk("rst_reg1", reg1_o, 32'h0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_err", {31'd0, inst_err_o}, 32'd0);
    rst = 1'b1;

    // ORI r2,r1,0xFF00
    in_valid = 1'b1; pc_i = 32'h0000_1000; inst_i = itype(6'b001101, 5'd1, 5'd2, 16'hFF00);
    #1;
    chk("ori_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ori_r1_addr", {27'd0, reg1_addr_o}, 32'd1);
    chk("ori_r2_read", {31'd0, reg2_read_o}, 32'd0);
    tick();
    chk("ori_valid", {31'd0, out_valid}, 32'd1);
    chk("ori_reg1", reg1_o, 32'h0000_00FF);
    chk("ori_reg2", reg2_o, 32'h0000_FF00);
    chk("ori_wd", {27'd0, wd_o}, 32'd2);
    chk("ori_wreg", {31'd0, wreg_o}, 32'd1);
    chk("ori_aluop", {24'd0, aluop_o}, 32'h25);
    chk("ori_alusel", {29'd0, alusel_o}, 32'd1);
    chk("ori_pc", pc_o, 32'h0000_1000);

    // OR r3,r1,r2 with EX and MEM both targeting r1
    pc_i = 32'h0000_1004; inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100101);
    ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hA5A5_0000;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h1111_1111;
    tick();
    chk("or_reg1_exfwd", reg1_o, 32'hA5A5_0000);
    chk("or_reg2", reg2_o, 32'h0000_0022);
    chk("or_wd", {27'd0, wd_o}, 32'd3);
    chk("or_pc", pc_o, 32'h0000_1004);

    // XOR r4,r2,r1 with MEM forwarding r2
    inst_i = rtype(5'd2, 5'd1, 5'd4, 5'd0, 6'b100110);
    ex_wreg_i = 1'b0; mem_wd_i = 5'd2; mem_wdata_i = 32'h3333_3333;
    tick();
    chk("xor_reg1_memfwd", reg1_o, 32'h3333_3333);
    chk("xor_reg2", reg2_o, 32'h0000_00FF);
    chk("xor_aluop", {24'd0, aluop_o}, 32'h26);

    // ORI r6,r0,0x1234: r0 never forwarded
    inst_i = itype(6'b001101, 5'd0, 5'd6, 16'h1234);
    ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'hDEAD_BEEF; mem_wreg_i = 1'b0;
    #1;
    chk("r0_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("r0_reg1", reg1_o, 32'h0);
    chk("r0_reg2", reg2_o, 32'h0000_1234);

    // LUI r7,0xABCD
    inst_i = itype(6'b001111, 5'd0, 5'd7, 16'hABCD); ex_wreg_i = 1'b0;
    #1;
    chk("lui_r1_read", {31'd0, reg1_read_o}, 32'd0);
    tick();
    chk("lui_reg1", reg1_o, 32'hABCD_0000);
    chk("lui_reg2", reg2_o, 32'hABCD_0000);
    chk("lui_wd", {27'd0, wd_o}, 32'd7);

    // SLL r8,r1,4
    inst_i = rtype(5'd0, 5'd1, 5'd8, 5'd4, 6'b000000);
    tick();
    chk("sll_reg1_sa", reg1_o, 32'd4);
    chk("sll_reg2", reg2_o, 32'h0000_00FF);
    chk("sll_aluop", {24'd0, aluop_o}, 32'h7C);
    chk("sll_alusel", {29'd0, alusel_o}, 32'd2);

    // Load-use: ANDI r5,r4,1 behind a load to r4
    inst_i = itype(6'b001100, 5'd4, 5'd5, 16'h0001);
    ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_is_load_i = 1'b1;
    #1;
    chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_hold_wd", {27'd0, wd_o}, 32'd8);
    ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
    #1;
    chk("lu_release", {31'd0, in_ready}, 32'd1);
    tick();
    chk("andi_valid", {31'd0, out_valid}, 32'd1);
    chk("andi_reg1", reg1_o, 32'h0000_0F0F);
    chk("andi_wd", {27'd0, wd_o}, 32'd5);
    chk("andi_aluop", {24'd0, aluop_o}, 32'h24);

    // Backpressure: XORI r9,r1,0x00F0 waits three cycles
    out_ready = 1'b0; inst_i = itype(6'b001110, 5'd1, 5'd9, 16'h00F0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_wd", {27'd0, wd_o}, 32'd5);
      chk("bp_reg1", reg1_o, 32'h0000_0F0F);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("xori_wd", {27'd0, wd_o}, 32'd9);
    chk("xori_reg2", reg2_o, 32'h0000_00F0);

    // Flush: ORI r10,r0,5 is not consumed
    inst_i = itype(6'b001101, 5'd0, 5'd10, 16'h0005); flush_i = 1'b1;
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_hold_wd", {27'd0, wd_o}, 32'd9);
    flush_i = 1'b0;
    tick();
    chk("fl_retry_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_retry_wd", {27'd0, wd_o}, 32'd10);
    chk("fl_retry_reg2", reg2_o, 32'h0000_0005);

    // Undecodable opcode 0x3F
    inst_i = 32'hFC00_0000;
    tick();
    chk("bad_valid", {31'd0, out_valid}, 32'd1);
    chk("bad_err", {31'd0, inst_err_o}, 32'd1);
    chk("bad_wreg", {31'd0, wreg_o}, 32'd0);
    chk("bad_aluop", {24'd0, aluop_o}, 32'h00);

    // All-zero word is a clean NOP
    inst_i = 32'h0;
    tick();
    chk("nop_err", {31'd0, inst_err_o}, 32'd0);
    chk("nop_wreg", {31'd0, wreg_o}, 32'd0);

    in_valid = 1'b0;
    tick();
    chk("idle_bubble", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges
    in_valid = 1'b1; pc_i = 32'h0000_0100; inst_i = itype(6'b001101, 5'd1, 5'd2, 16'hFF00);
    tick();
    chk("pre_rst_pc", pc_o, 32'h0000_0100);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_reg1", reg1_o, 32'h0);
    chk("arst_wreg", {31'd0, wreg_o}, 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
